// File: rtl/rom_loader_router_pkg.sv
// rom_loader_pkg: shared types and constants for the ROM download router.
// Holds the per-port FIFO entry layout, the ioctl index codes and the
// load-sequencing state encoding exposed on the router's debug output.
package rom_loader_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // Widest word address carried by a FIFO entry; ports use the low ADDR_W-1 bits.
  localparam int DL_ADDR_MAX = 31;

  typedef struct packed {
    logic [DL_ADDR_MAX-1:0] addr;  // word address relative to the port window
    logic [7:0]             data;  // download byte
    logic [1:0]             ds;    // {upper, lower} byte select
  } dl_entry_t;

  typedef enum logic [1:0] {
    LD_WAIT  = 2'd0,  // no ROM download seen yet
    LD_ROM   = 2'd1,  // index-0 download in progress
    LD_DRAIN = 2'd2,  // download ended, waiting for FIFOs and ports to empty
    LD_DONE  = 2'd3   // ROM fully delivered
  } load_state_t;

endpackage

// File: rtl/rom_loader_router_if.sv
// rom_loader_router_if: ioctl download bus plus the per-port toggle handshake.
//
// Handshake: a port is idle while port_req[i] == port_ack[i]. The router
// toggles port_req[i] to present a new {port_a, port_d, port_ds} word and holds
// those outputs stable until the target toggles port_ack[i] to match. Only one
// request per port is ever outstanding. ioctl_wait asks the HPS to stop
// strobing ioctl_wr until it drops.
interface rom_loader_router_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 25
);
  logic                                ioctl_download;
  logic [7:0]                          ioctl_index;
  logic                                ioctl_wr;
  logic [ADDR_W-1:0]                   ioctl_addr;
  logic [7:0]                          ioctl_dout;
  logic                                ioctl_wait;
  logic [NUM_PORTS-1:0]                port_req;
  logic [NUM_PORTS-1:0]                port_ack;
  logic [NUM_PORTS-1:0][ADDR_W-2:0]    port_a;
  logic [NUM_PORTS-1:0][15:0]          port_d;
  logic [NUM_PORTS-1:0][1:0]           port_ds;

  // HPS / memory side
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  port_req, port_a, port_d, port_ds,
    output port_ack
  );

  // Router side
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output port_req, port_a, port_d, port_ds,
    input  port_ack
  );
endinterface

// File: rtl/rom_loader_router_dl_fifo.sv
// dl_fifo: synchronous FIFO of download entries with a combinational head.
// A push while full is ignored; a pop while empty is ignored.
module dl_fifo
  import rom_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  dl_entry_t              din,
  input  logic                   pop,
  output dl_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free_cnt
);

  localparam int PW = $clog2(DEPTH);

  dl_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign dout     = mem[rd_ptr];
  assign free_cnt = (PW+1)'(DEPTH) - count;

  // Pointer and occupancy tracking; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rom_loader_router.sv
// rom_loader_router: routes hps_io ioctl download bytes to NUM_PORTS memory
// ports by address window, stalls the HPS when any port FIFO nears full,
// sequences the core reset around ROM loading and captures core_mod/DIP bytes.
// Optional feature macro: ROM_LOADER_DIP_EN adds the dip_sw port and index-254
// DIP capture; without it index-254 bytes are ignored.
module rom_loader_router
  import rom_loader_pkg::*;
#(
  parameter int          NUM_PORTS  = 2,
  parameter int          ADDR_W     = 25,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  rom_loader_router_if.slave               bus,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] region_base,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] region_end,
  input  logic                             reset_req,
  output logic                             core_reset,
  output logic                             rom_loaded,
  output logic [7:0]                       core_mod,
`ifdef ROM_LOADER_DIP_EN
  output logic [7:0][7:0]                  dip_sw,
`endif
  output logic                             overflow,
  output load_state_t                      load_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                             wr_d;
  logic                             cap_valid;
  logic [7:0]                       cap_index;
  logic [7:0]                       cap_data;
  logic [ADDR_W-1:0]                cap_addr;
  logic [ADDR_W-1:0]                rel [NUM_PORTS];
  dl_entry_t                        push_entry [NUM_PORTS];
  dl_entry_t                        head [NUM_PORTS];
  logic [CNT_W-1:0]                 free_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0]             hit;
  logic [NUM_PORTS-1:0]             fifo_push;
  logic [NUM_PORTS-1:0]             fifo_pop;
  logic [NUM_PORTS-1:0]             fifo_full;
  logic [NUM_PORTS-1:0]             fifo_empty;
  logic [NUM_PORTS-1:0]             low_space;
  logic [NUM_PORTS-1:0]             port_idle;
  logic [NUM_PORTS-1:0]             req_q;
  logic [NUM_PORTS-1:0][ADDR_W-2:0] a_q;
  logic [NUM_PORTS-1:0][15:0]       d_q;
  logic [NUM_PORTS-1:0][1:0]        ds_q;
  logic                             rom_blocked;
  logic                             rom_dl;
  logic                             drained;
  logic                             ioctl_wait_q;
  logic                             load_cond;
  logic [15:0]                      hold_cnt;
  load_state_t                      state_q;
  load_state_t                      state_d;

  assign bus.port_req   = req_q;
  assign bus.port_a     = a_q;
  assign bus.port_d     = d_q;
  assign bus.port_ds    = ds_q;
  assign bus.ioctl_wait = ioctl_wait_q;
  assign load_state     = state_q;

  // Register one byte per rising edge of ioctl_wr during a download.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_d      <= 1'b0;
      cap_valid <= 1'b0;
      cap_index <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
    end else begin
      wr_d      <= bus.ioctl_wr;
      cap_valid <= bus.ioctl_wr && !wr_d && bus.ioctl_download;
      cap_index <= bus.ioctl_index;
      cap_addr  <= bus.ioctl_addr;
      cap_data  <= bus.ioctl_dout;
    end
  end

  // Window match, relative-address entry build, all-or-nothing push, pop select.
  always_comb begin
    hit       = '0;
    fifo_pop  = '0;
    port_idle = '0;
    low_space = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rel[i]              = cap_addr - region_base[i];
      push_entry[i]       = '0;
      push_entry[i].addr  = DL_ADDR_MAX'(rel[i][ADDR_W-1:1]);
      push_entry[i].data  = cap_data;
      push_entry[i].ds    = {rel[i][0], ~rel[i][0]};
      hit[i]       = cap_valid && (cap_index == IDX_ROM) &&
                     (cap_addr >= region_base[i]) && (cap_addr < region_end[i]);
      port_idle[i] = (req_q[i] == bus.port_ack[i]);
      fifo_pop[i]  = port_idle[i] && !fifo_empty[i];
      low_space[i] = (free_cnt[i] <= CNT_W'(1));
    end
    // A full FIFO among the hits drops the byte everywhere, never a partial broadcast.
    rom_blocked = |(hit & fifo_full);
    fifo_push   = rom_blocked ? '0 : hit;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk_sys),
      .rst      (reset),
      .push     (fifo_push[g]),
      .din      (push_entry[g]),
      .pop      (fifo_pop[g]),
      .dout     (head[g]),
      .full     (fifo_full[g]),
      .empty    (fifo_empty[g]),
      .free_cnt (free_cnt[g])
    );
  end

  // Port engines: latch the FIFO head and toggle the request when idle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      a_q   <= '0;
      d_q   <= '0;
      ds_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (fifo_pop[i]) begin
          a_q[i]   <= head[i].addr[ADDR_W-2:0];
          d_q[i]   <= {head[i].data, head[i].data};
          ds_q[i]  <= head[i].ds;
          req_q[i] <= ~req_q[i];
        end
      end
    end
  end

  // Sticky overflow and registered HPS stall; one spare slot absorbs the lag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      overflow     <= 1'b0;
      ioctl_wait_q <= 1'b0;
    end else begin
      overflow     <= overflow | rom_blocked;
      ioctl_wait_q <= (|low_space) | overflow | rom_blocked;
    end
  end

  // core_mod takes the last index-1 byte regardless of address.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      core_mod <= '0;
    end else if (cap_valid && (cap_index == IDX_MOD)) begin
      core_mod <= cap_data;
    end
  end

`ifdef ROM_LOADER_DIP_EN
  // DIP bytes live at index 254, addresses 0..7.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip_sw <= '0;
    end else if (cap_valid && (cap_index == IDX_DIP) && (cap_addr[ADDR_W-1:3] == '0)) begin
      dip_sw[cap_addr[2:0]] <= cap_data;
    end
  end
`endif

  assign rom_dl  = bus.ioctl_download && (bus.ioctl_index == IDX_ROM);
  assign drained = (&fifo_empty) && (&port_idle) && !cap_valid;

  // Load sequencer state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= LD_WAIT;
    else       state_q <= state_d;
  end

  // Load sequencer next state: ROM download, then drain, then done for good.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_WAIT:  if (rom_dl) state_d = LD_ROM;
      LD_ROM:   if (!rom_dl) state_d = LD_DRAIN;
      LD_DRAIN: begin
        if (rom_dl)       state_d = LD_ROM;
        else if (drained) state_d = LD_DONE;
      end
      LD_DONE:  state_d = LD_DONE;
      default:  state_d = LD_WAIT;
    endcase
  end

  // rom_loaded is sticky once the sequencer reaches done.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) rom_loaded <= 1'b0;
    else       rom_loaded <= rom_loaded | (state_d == LD_DONE);
  end

  assign load_cond = reset_req | ~rom_loaded | rom_dl;

  // Core reset stretcher: reload while loading, then count down to release.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_cnt   <= RESET_HOLD;
      core_reset <= 1'b1;
    end else begin
      core_reset <= load_cond | (hold_cnt != 16'd0);
      if (load_cond)              hold_cnt <= RESET_HOLD;
      else if (hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_rom_loader_router.sv
// tb_rom_loader_router: scoreboard bench for rom_loader_router with two ports,
// FIFO_DEPTH=4 and RESET_HOLD=16. Define ROM_LOADER_DIP_EN to cover DIP capture.
module tb_rom_loader_router;
  import rom_loader_pkg::*;

  localparam int          NP    = 2;
  localparam int          AW    = 25;
  localparam int          DEPTH = 4;
  localparam logic [15:0] HOLD  = 16'd16;
  localparam int          EW    = (AW - 1) + 16 + 2;

  logic                      clk_sys   = 1'b0;
  logic                      reset     = 1'b1;
  logic                      reset_req = 1'b0;
  logic [NP-1:0][AW-1:0]     region_base;
  logic [NP-1:0][AW-1:0]     region_end;
  logic                      core_reset;
  logic                      rom_loaded;
  logic [7:0]                core_mod;
`ifdef ROM_LOADER_DIP_EN
  logic [7:0][7:0]           dip_sw;
`endif
  logic                      overflow;
  load_state_t               load_state;

  logic [1:0]                hold_ack = 2'b11;
  logic [1:0]                hold_val = 2'b00;
  int                        ack_dly [2] = '{0, 0};
  logic [EW-1:0]             exp_q0[$];
  logic [EW-1:0]             exp_q1[$];
  int                        n_checks = 0;
  int                        n_fail   = 0;

  rom_loader_router_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

  rom_loader_router #(
    .NUM_PORTS  (NP),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .RESET_HOLD (HOLD)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .bus         (bus.slave),
    .region_base (region_base),
    .region_end  (region_end),
    .reset_req   (reset_req),
    .core_reset  (core_reset),
    .rom_loaded  (rom_loaded),
    .core_mod    (core_mod),
`ifdef ROM_LOADER_DIP_EN
    .dip_sw      (dip_sw),
`endif
    .overflow    (overflow),
    .load_state  (load_state)
  );

  // Clock
  always #5 clk_sys = ~clk_sys;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard model: expected port words for an index-0 byte.
  task automatic model_rom_byte(input logic [AW-1:0] addr, input logic [7:0] d);
    logic [AW-1:0] rel;
    for (int p = 0; p < NP; p++) begin
      if (addr >= region_base[p] && addr < region_end[p]) begin
        rel = addr - region_base[p];
        if (p == 0) exp_q0.push_back({rel[AW-1:1], d, d, rel[0], ~rel[0]});
        else        exp_q1.push_back({rel[AW-1:1], d, d, rel[0], ~rel[0]});
      end
    end
  endtask

  // Target responder: checks each presented word, then acks after 0..2 cycles.
  always @(negedge clk_sys) begin
    for (int p = 0; p < NP; p++) begin
      if (hold_ack[p]) begin
        bus.port_ack[p] = hold_val[p];
      end else if (bus.port_req[p] != bus.port_ack[p]) begin
        if (ack_dly[p] > 0) begin
          ack_dly[p]--;
        end else begin
          if (p == 0) begin
            check("port0_pending", 64'(exp_q0.size() != 0), 64'd1);
            if (exp_q0.size() != 0)
              check("port0_word", 64'({bus.port_a[0], bus.port_d[0], bus.port_ds[0]}), 64'(exp_q0.pop_front()));
          end else begin
            check("port1_pending", 64'(exp_q1.size() != 0), 64'd1);
            if (exp_q1.size() != 0)
              check("port1_word", 64'({bus.port_a[1], bus.port_d[1], bus.port_ds[1]}), 64'(exp_q1.pop_front()));
          end
          bus.port_ack[p] = ~bus.port_ack[p];
          ack_dly[p] = $urandom_range(0, 2);
        end
      end
    end
  end

  // Driver: one write strobe held for two cycles (only its rising edge counts).
  task automatic pulse_wr(input logic [7:0] idx, input logic [AW-1:0] addr, input logic [7:0] d);
    @(negedge clk_sys);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = addr;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    bus.ioctl_wr    = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic send_rom(input logic [AW-1:0] addr, input logic [7:0] d);
    int n = 0;
    while (bus.ioctl_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("stall_released", 64'(n < 200), 64'd1);
    model_rom_byte(addr, d);
    pulse_wr(IDX_ROM, addr, d);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || bus.port_req != bus.port_ack) && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check("drain_done", 64'(n < 300), 64'd1);
  endtask

  // Main sequence
  initial begin
    logic [AW-1:0] ra;
    int n;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    region_base[0] = 25'h0;      region_end[0] = 25'h30000;
    region_base[1] = 25'h30000;  region_end[1] = 25'hA0000;

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_port_req", 64'(bus.port_req), 64'd0);
    check("rst_ioctl_wait", 64'(bus.ioctl_wait), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    check("rst_core_mod", 64'(core_mod), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_load_state", 64'(load_state), 64'(LD_WAIT));
`ifdef ROM_LOADER_DIP_EN
    check("rst_dip_sw", 64'(dip_sw), 64'd0);
`endif
    reset    = 1'b0;
    hold_ack = 2'b00;
    @(negedge clk_sys);

    // Broadcast of one byte into port 1's window, with latency checks
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = IDX_ROM;
    model_rom_byte(25'h30001, 8'h5A);
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h30001;
    bus.ioctl_dout = 8'h5A;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    check("req_after_1", 64'(bus.port_req), 64'd0);
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    check("req_after_2", 64'(bus.port_req), 64'd0);
    @(negedge clk_sys);
    check("req_toggle", 64'(bus.port_req), 64'b10);
    check("bcast_port_a", 64'(bus.port_a[1]), 64'd0);
    check("bcast_port_d", 64'(bus.port_d[1]), 64'h5A5A);
    check("bcast_port_ds", 64'(bus.port_ds[1]), 64'b10);
    wait_drain();

    // Window boundaries, misses and random traffic
    send_rom(25'h00000, 8'h01);
    send_rom(25'h2FFFF, 8'h02);
    send_rom(25'h30000, 8'h03);
    send_rom(25'h9FFFF, 8'h04);
    send_rom(25'hA0000, 8'h05);
    send_rom(25'h1FFFF8, 8'h06);
    for (int k = 0; k < 10; k++) begin
      ra = 25'($urandom_range(0, 32'hBFFFF));
      send_rom(ra, 8'($urandom_range(0, 255)));
    end
    wait_drain();

    // Overlapping windows: bytes in the overlap go to both ports
    region_base[1] = 25'h20000;
    send_rom(25'h20000, 8'hC3);
    send_rom(25'h2FFFF, 8'h3C);
    send_rom(25'h10000, 8'h77);
    send_rom(25'h30002, 8'h88);
    for (int k = 0; k < 6; k++) begin
      ra = 25'($urandom_range(32'h18000, 32'h38000));
      send_rom(ra, 8'($urandom_range(0, 255)));
    end
    wait_drain();
    check("no_overflow_paced", 64'(overflow), 64'd0);

    // Download end: rom_loaded, then reset stretch of HOLD+1 cycles
    check("core_reset_during_dl", 64'(core_reset), 64'd1);
    bus.ioctl_download = 1'b0;
    n = 0;
    while (!rom_loaded && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("rom_loaded_set", 64'(rom_loaded), 64'd1);
    check("load_state_done", 64'(load_state), 64'(LD_DONE));
    repeat (16) @(negedge clk_sys);
    check("core_reset_held", 64'(core_reset), 64'd1);
    @(negedge clk_sys);
    check("core_reset_release", 64'(core_reset), 64'd0);
    reset_req = 1'b1;
    @(negedge clk_sys);
    reset_req = 1'b0;
    check("reset_req_reassert", 64'(core_reset), 64'd1);
    check("rom_loaded_sticky", 64'(rom_loaded), 64'd1);

    // Index 1 and index 254 captures produce no port traffic
    bus.ioctl_index    = IDX_MOD;
    bus.ioctl_download = 1'b1;
    pulse_wr(IDX_MOD, 25'h3, 8'h0B);
    check("core_mod", 64'(core_mod), 64'h0B);
    pulse_wr(IDX_DIP, 25'h3, 8'hA5);
`ifdef ROM_LOADER_DIP_EN
    check("dip_sw3", 64'(dip_sw[3]), 64'hA5);
    check("dip_sw_others", 64'({dip_sw[7:4], dip_sw[2:0]}), 64'd0);
`else
    check("core_mod_after_dip", 64'(core_mod), 64'h0B);
`endif
    check("no_req_side_idx", 64'(bus.port_req ^ bus.port_ack), 64'd0);
    bus.ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Mid-transfer reset with port 1 holding an outstanding request
    hold_val[1] = bus.port_ack[1];
    hold_ack[1] = 1'b1;
    bus.ioctl_index    = IDX_ROM;
    bus.ioctl_download = 1'b1;
    pulse_wr(IDX_ROM, 25'h40000, 8'h11);
    pulse_wr(IDX_ROM, 25'h40002, 8'h22);
    check("req_outstanding", 64'(bus.port_req[1] != bus.port_ack[1]), 64'd1);
    #3 reset = 1'b1;
    #1;
    check("midrst_port_req", 64'(bus.port_req), 64'd0);
    check("midrst_core_reset", 64'(core_reset), 64'd1);
    check("midrst_rom_loaded", 64'(rom_loaded), 64'd0);
    check("midrst_core_mod", 64'(core_mod), 64'd0);
    check("midrst_wait", 64'(bus.ioctl_wait), 64'd0);
    hold_val = 2'b00;
    hold_ack = 2'b11;
    bus.ioctl_download = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clk_sys);
    reset    = 1'b0;
    hold_ack = 2'b00;
    repeat (10) @(negedge clk_sys);
    check("flushed_no_req", 64'(bus.port_req), 64'd0);

    // Stall: port 0 held busy, five bytes ignoring ioctl_wait
    hold_val[0] = 1'b1;
    hold_ack[0] = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_download = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      pulse_wr(IDX_ROM, 25'(32'h100 + k), 8'(k));
      if (k == 2) check("wait_after_2", 64'(bus.ioctl_wait), 64'd0);
      if (k == 3) check("wait_after_3", 64'(bus.ioctl_wait), 64'd1);
      if (k == 4) check("overflow_after_4", 64'(overflow), 64'd0);
      if (k == 5) check("overflow_after_5", 64'(overflow), 64'd1);
    end
    check("stall_port_req", 64'(bus.port_req), 64'd0);
    check("stall_wait_held", 64'(bus.ioctl_wait), 64'd1);
    bus.ioctl_download = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader_router.md
# rom_loader_router

Parametrised ROM download router between `hps_io` ioctl and the SDRAM/BRAM ports of an arcade core. It supports N target ports, each with a programmable address window, and broadcasts each download byte to every port whose window matches. Each port has its own FIFO and a toggle req/ack handshake, and the block stalls the HPS via `ioctl_wait` when a FIFO is nearly full. It also generates the core reset from load-complete and the reset requests, and captures the `core_mod` byte and the DIP bytes.

## Interface
- `NUM_PORTS`, 2: number of target ports (1..8).
- `ADDR_W`, 25: ioctl address width.
- `FIFO_DEPTH`, 4: entries per port FIFO (power of two, ≥2).
- `RESET_HOLD`, 16'hFFFF: core reset stretch in clk_sys cycles.
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ioctl_download` in 1: download active.
- `ioctl_index` in 8: 0 = ROM, 1 = core_mod, 254 = DIP.
- `ioctl_wr` in 1: byte strobe. A byte is captured on its rising edge only.
- `ioctl_addr` in ADDR_W: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: stall request to HPS.
- `region_base` in NUM_PORTS×ADDR_W: inclusive window start per port.
- `region_end` in NUM_PORTS×ADDR_W: exclusive window end per port.
- `port_req` out NUM_PORTS: toggle request per port.
- `port_ack` in NUM_PORTS: toggle acknowledge per port.
- `port_a` out NUM_PORTS×(ADDR_W-1): word address, equal to (addr − base) >> 1.
- `port_d` out NUM_PORTS×16: {byte, byte}.
- `port_ds` out NUM_PORTS×2: {addr[0], ~addr[0]} of the relative address.
- `reset_req` in 1: OSD reset / user button.
- `core_reset` out 1: reset to the game core.
- `rom_loaded` out 1: sticky, set when the first load completes.
- `core_mod` out 8: last byte written at index 1.
- `dip_sw` out 8×8: DIP bytes (present only with `ROM_LOADER_DIP_EN`).
- `overflow` out 1: sticky flag for a dropped byte.

## Operation
- Capture event: `ioctl_wr` & ~`ioctl_wr_d` & `ioctl_download`.
- Index 0 capture:
  - Compute `hit[i]` = base_i ≤ addr < end_i.
  - Push {relative addr, data} into every FIFO with `hit[i]=1` in the same cycle.
  - No hits: the byte is discarded silently.
  - Any hit FIFO full: the byte is dropped for all ports, so no partial broadcast occurs, and `overflow` is set.
- Index 1 capture: `core_mod` ← data, regardless of address.
- Port engine, per port, idle when `port_req[i]==port_ack[i]`:
  - Idle and FIFO not empty: pop the head, register `port_a`/`port_d`/`port_ds`, toggle `port_req[i]`.
  - Outputs stay stable until `ack` matches.
  - One outstanding request per port.
- `ioctl_wait` = 1 when any port has ≤1 free entry or `overflow` is set.
- Reset generator:
  - Counter loads `RESET_HOLD` while `reset_req` | ~`rom_loaded` | (download at index 0).
  - Otherwise the counter decrements to 0.
  - `core_reset` = counter ≠ 0, registered.
- `rom_loaded` sets on the cycle where the index-0 download has ended and all FIFOs are empty with no outstanding requests. It is never cleared except by `reset`.
- Reset values:
  - `port_req`=0, FIFOs empty, `ioctl_wait`=0.
  - `core_reset`=1, `rom_loaded`=0, `core_mod`=0, `dip_sw`=0, `overflow`=0.
  - Counter = `RESET_HOLD`.
- Asserting `reset` mid-transfer flushes the FIFOs and returns `port_req` to 0. The SDRAM controller is reset by the same signal.

## Timing
- Push happens 1 cycle after the `ioctl_wr` rising edge.
- With an empty FIFO and the port idle, `port_req` toggles 2 cycles after the edge.
- After an `ack` toggle, the next `req` may toggle on the following cycle.
- Simultaneous push and pop on the same port is allowed and leaves the count unchanged.
- A push into a full FIFO with a pop in the same cycle still counts as full and is dropped.
- `ioctl_wait` is registered and asserts one cycle after the occupancy crosses the threshold. The ≤1 threshold covers that latency.
- `core_reset` deasserts exactly `RESET_HOLD`+1 cycles after the last loading condition clears.

## Configuration
- `ROM_LOADER_DIP_EN` defined: an index-254 capture with addr[ADDR_W-1:3]==0 writes `dip_sw[addr[2:0]]`, and the `dip_sw` port exists.
- Macro undefined: the `dip_sw` port is absent and index-254 bytes are ignored.

## Structure
- Package `rom_loader_pkg` holds:
  - `dl_entry_t` struct {addr, data, ds}.
  - Localparams `IDX_ROM`=0, `IDX_MOD`=1, `IDX_DIP`=254.
- Sub-module `dl_fifo`: synchronous FIFO of `dl_entry_t` with full, empty and `free_cnt` outputs, instantiated NUM_PORTS times.

## Test plan
- Broadcast:
  - Setup: NUM_PORTS=2, port0 window [0,0x30000), port1 window [0x30000,0xA0000).
  - Stimulus: byte 0x5A at addr 0x30001.
  - Response: port1 gets `port_a`=0, `port_ds`=2'b10, `port_d`=0x5A5A; port0 does not toggle.
- Handshake stall:
  - Stimulus: hold `port_ack` for port 0 fixed, write 5 bytes into its window with FIFO_DEPTH=4.
  - Response: `ioctl_wait` rises after the 3rd push; the 5th byte sets `overflow` if the HPS ignores the wait.
- Reset generator:
  - Stimulus: finish the index-0 download with the FIFOs drained, RESET_HOLD=16.
  - Response: `rom_loaded`=1, then `core_reset` falls 17 cycles later; a `reset_req` pulse reasserts it immediately.
- Index 1 and DIP:
  - Stimulus: write 0x0B at index 1, then 0xA5 at index 254 addr 3.
  - Response: `core_mod`=0x0B; `dip_sw[3]`=0xA5 with the macro defined, unchanged without it.
- Mid-transfer reset:
  - Stimulus: assert `reset` while a request is outstanding.
  - Response: next cycle `port_req`=0, FIFOs empty, `core_reset`=1, `rom_loaded`=0.
